// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two 32-bit requester ports and the byte-wide SRAM port.
// slave = the arbiter; master = requesters plus the SRAM model.
interface mem_port_arbiter_if #(
  parameter int AW = 16
);
  // Handshake: req is a level held until gnt. gnt is a one-cycle pulse and rw/addr/wdata
  // are sampled in that cycle. done pulses once per grant, with err and (for a good read)
  // rdata valid in that cycle. mem_en strobes one byte beat; mem_rdata answers a cycle later.
  logic          p0_req,   p1_req;
  logic          p0_rw,    p1_rw;
  logic [31:0]   p0_addr,  p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic          p0_gnt,   p1_gnt;
  logic          p0_done,  p1_done;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          p0_err,   p1_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    output p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata, p0_err, p1_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    input  p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata, p0_err, p1_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that splits each 32-bit access into four little-endian byte beats
// on a shared synchronous 8-bit SRAM port, returning the response to the granted port.
module mem_port_arbiter #(
  parameter logic [31:0] MEM_TOP = 32'h1000,
  parameter int          AW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    bc;
  logic          last;
  logic          cur_port;
  logic          cur_rw;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic          rd_pend;
  logic [1:0]    rd_lane;
  logic [23:0]   stage;

  logic          gnt_any;
  logic          sel;
  logic          g_rw;
  logic [31:0]   g_addr;
  logic [31:0]   g_wdata;
  logic          g_err;
  logic [1:0]    bc_inc;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // gnt is combinational so the request fields are captured in the very cycle it pulses;
  // it is gated by rst_n so every output reads 0 while reset is held.
  assign gnt_any = rst_n && (state == IDLE) && (bus.p0_req || bus.p1_req);
  assign sel     = (bus.p0_req && bus.p1_req) ? ~last : bus.p1_req;
  assign bus.p0_gnt = gnt_any && !sel;
  assign bus.p1_gnt = gnt_any &&  sel;

  assign g_rw    = sel ? bus.p1_rw    : bus.p0_rw;
  assign g_addr  = sel ? bus.p1_addr  : bus.p0_addr;
  assign g_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
  // 33-bit sum so an address near 2^32 wrapping past zero still counts as out of range.
  assign g_err   = ({1'b0, g_addr} + 33'd3) > {1'b0, MEM_TOP};
  assign bc_inc  = bc + 2'd1;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bc            <= 2'd0;
      last          <= 1'b0;
      cur_port      <= 1'b0;
      cur_rw        <= 1'b0;
      cur_addr      <= '0;
      cur_wdata     <= '0;
      rd_pend       <= 1'b0;
      rd_lane       <= 2'd0;
      stage         <= '0;
      bus.p0_done   <= 1'b0;
      bus.p1_done   <= 1'b0;
      bus.p0_err    <= 1'b0;
      bus.p1_err    <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.p0_done <= 1'b0;
      bus.p1_done <= 1'b0;
      bus.mem_en  <= 1'b0;
      bus.mem_we  <= 1'b0;
      rd_pend     <= 1'b0;

      // Lanes 0..2 land in the staging word; lane 3 goes straight into rdata from DRAIN.
      if (rd_pend) begin
        case (rd_lane)
          2'd0:    stage[7:0]   <= bus.mem_rdata;
          2'd1:    stage[15:8]  <= bus.mem_rdata;
          2'd2:    stage[23:16] <= bus.mem_rdata;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (gnt_any) begin
            last      <= sel;
            cur_port  <= sel;
            cur_rw    <= g_rw;
            cur_addr  <= g_addr[AW-1:0];
            cur_wdata <= g_wdata;
            bc        <= 2'd0;
            if (g_err) begin
              state <= RESP;
              if (sel) begin
                bus.p1_done <= 1'b1;
                bus.p1_err  <= 1'b1;
              end else begin
                bus.p0_done <= 1'b1;
                bus.p0_err  <= 1'b1;
              end
            end else begin
              state         <= ISSUE;
              bus.mem_en    <= 1'b1;
              bus.mem_we    <= g_rw;
              bus.mem_addr  <= g_addr[AW-1:0];
              bus.mem_wdata <= g_wdata[7:0];
            end
          end
        end

        ISSUE: begin
          rd_pend <= ~cur_rw;
          rd_lane <= bc;
          if (bc == 2'd3) begin
            if (cur_rw) begin
              state <= RESP;
              if (cur_port) begin
                bus.p1_done <= 1'b1;
                bus.p1_err  <= 1'b0;
              end else begin
                bus.p0_done <= 1'b1;
                bus.p0_err  <= 1'b0;
              end
            end else begin
              state <= DRAIN;
            end
          end else begin
            bc            <= bc_inc;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= cur_rw;
            bus.mem_addr  <= cur_addr + AW'(bc_inc);
            bus.mem_wdata <= byte_sel(cur_wdata, bc_inc);
          end
        end

        DRAIN: begin
          state <= RESP;
          if (cur_port) begin
            bus.p1_done  <= 1'b1;
            bus.p1_err   <= 1'b0;
            bus.p1_rdata <= {bus.mem_rdata, stage};
          end else begin
            bus.p0_done  <= 1'b1;
            bus.p0_err   <= 1'b0;
            bus.p0_rdata <= {bus.mem_rdata, stage};
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level memory model feeds expected
// responses and beats into queues that negedge monitors pop and compare.
module tb_mem_port_arbiter;
  localparam int          AW      = 16;
  localparam logic [31:0] MEM_TOP = 32'h1000;
  localparam int          EW      = 38;  // {port, err, is_read, data[31:0], latency[2:0]}
  localparam int          BW      = 25;  // {we, addr[15:0], wdata[7:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.MEM_TOP(MEM_TOP), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- SRAM model (1-cycle read latency) ----------------
  logic [7:0] sram [0:65535];
  logic [7:0] sram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            sram_q <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = sram_q;

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]    ref_mem [0:65535];
  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] beat_q[$];
  logic [31:0]   exp_rd [2];
  int            n_chk = 0;
  int            n_pass = 0;
  int            g_cyc = 0;
  int            gord[$];
  int            gcy[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Word access as the spec describes it: range test, then four ascending byte addresses.
  function automatic void model_push(input bit port, input bit rw, input logic [31:0] addr,
                                     input logic [31:0] wd);
    logic [32:0] endp;
    logic [31:0] word;
    logic [15:0] a;
    endp = {1'b0, addr} + 33'd3;
    word = 32'h0;
    if (endp > {1'b0, MEM_TOP}) begin
      exp_q.push_back({port, 1'b1, 1'b0, 32'h0, 3'd1});
      return;
    end
    for (int k = 0; k < 4; k++) begin
      a = addr[15:0] + 16'(k);
      if (rw) begin
        ref_mem[a] = wd[8*k +: 8];
        beat_q.push_back({1'b1, a, wd[8*k +: 8]});
      end else begin
        beat_q.push_back({1'b0, a, 8'h00});
        word[8*k +: 8] = ref_mem[a];
      end
    end
    exp_q.push_back({port, 1'b0, ~rw, word, rw ? 3'd5 : 3'd6});
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [BW-1:0] b;
    if (bus.p0_gnt || bus.p1_gnt) g_cyc = cyc;
    if (bus.p0_done || bus.p1_done) begin
      chk("done_both", {63'h0, bus.p0_done & bus.p1_done}, 64'h0);
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 64'h1, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("done_port", {63'h0, bus.p1_done}, {63'h0, e[37]});
        chk("done_err", {63'h0, e[37] ? bus.p1_err : bus.p0_err}, {63'h0, e[36]});
        chk("done_latency", 64'(cyc - g_cyc), {61'h0, e[2:0]});
        if (e[35]) exp_rd[e[37]] = e[34:3];
      end
      chk("p0_rdata", {32'h0, bus.p0_rdata}, {32'h0, exp_rd[0]});
      chk("p1_rdata", {32'h0, bus.p1_rdata}, {32'h0, exp_rd[1]});
    end
    if (bus.mem_en) begin
      if (beat_q.size() == 0) begin
        chk("beat_unexpected", 64'h1, 64'h0);
      end else begin
        b = beat_q.pop_front();
        chk("beat_we", {63'h0, bus.mem_we}, {63'h0, b[24]});
        chk("beat_addr", {48'h0, bus.mem_addr}, {48'h0, b[23:8]});
        if (b[24]) chk("beat_wdata", {56'h0, bus.mem_wdata}, {56'h0, b[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input bit port, input bit rw, input logic [31:0] addr,
                          input logic [31:0] wd);
    if (port) begin
      bus.p1_rw = rw; bus.p1_addr = addr; bus.p1_wdata = wd;
    end else begin
      bus.p0_rw = rw; bus.p0_addr = addr; bus.p0_wdata = wd;
    end
  endtask

  task automatic rand_params(input bit port, input bit rw_mode);
    set_port(port, rw_mode ? 1'($urandom_range(0, 1)) : 1'b0,
             32'($urandom_range(0, 32'h0FFD)), $urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},   {62'h0, bus.p1_gnt, bus.p0_gnt}, 64'h0);
    chk({tag, "_done"},  {62'h0, bus.p1_done, bus.p0_done}, 64'h0);
    chk({tag, "_err"},   {62'h0, bus.p1_err, bus.p0_err}, 64'h0);
    chk({tag, "_rdata"}, {bus.p1_rdata, bus.p0_rdata}, 64'h0);
    chk({tag, "_mem"},   {38'h0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'h0);
    chk({tag, "_state"}, {62'h0, state_dbg}, 64'h0);
  endtask

  // Single request: raise req, wait for gnt, scramble fields, wait for the response.
  task automatic issue(input bit port, input bit rw, input logic [31:0] addr,
                       input logic [31:0] wd);
    bit got = 0;
    @(posedge clk); #1;
    set_port(port, rw, addr, wd);
    if (port) bus.p1_req = 1'b1; else bus.p0_req = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (port ? bus.p1_gnt : bus.p0_gnt) got = 1;
    end
    if (!got) begin
      chk("gnt_timeout", 64'h0, 64'h1);
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      return;
    end
    model_push(port, rw, addr, wd);
    @(posedge clk); #1;
    if (port) bus.p1_req = 1'b0; else bus.p0_req = 1'b0;
    set_port(port, ~rw, $urandom, $urandom);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'h0);
      exp_q.delete();
      beat_q.delete();
    end
  endtask

  // Requests held high; each grant reloads fresh random fields until n grants are seen.
  task automatic run_held(input bit en0, input bit en1, input int n0, input int n1,
                          input bit rw_mode);
    int g0 = 0, g1 = 0;
    bit gg0, gg1, fin = 0;
    gord.delete(); gcy.delete();
    @(posedge clk); #1;
    if (en0) begin rand_params(0, rw_mode); bus.p0_req = 1'b1; end
    if (en1) begin rand_params(1, rw_mode); bus.p1_req = 1'b1; end
    for (int i = 0; i < 600 && !fin; i++) begin
      @(negedge clk);
      gg0 = bus.p0_gnt; gg1 = bus.p1_gnt;
      if (gg0) begin
        model_push(0, bus.p0_rw, bus.p0_addr, bus.p0_wdata);
        gord.push_back(0); gcy.push_back(cyc); g0++;
      end
      if (gg1) begin
        model_push(1, bus.p1_rw, bus.p1_addr, bus.p1_wdata);
        gord.push_back(1); gcy.push_back(cyc); g1++;
      end
      @(posedge clk); #1;
      if (gg0) begin if (g0 >= n0) bus.p0_req = 1'b0; else rand_params(0, rw_mode); end
      if (gg1) begin if (g1 >= n1) bus.p1_req = 1'b0; else rand_params(1, rw_mode); end
      fin = (g0 >= n0) && (g1 >= n1) && (exp_q.size() == 0);
    end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    if (!fin) chk("held_timeout", 64'h0, 64'h1);
  endtask

  // Write to 0x20 cut short by reset after its second beat.
  task automatic reset_mid_write();
    bit got = 0;
    @(posedge clk); #1;
    set_port(0, 1'b1, 32'h20, 32'h11223344);
    bus.p0_req = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.p0_gnt) got = 1;
    end
    chk("rst_mid_gnt", {63'h0, got}, 64'h1);
    beat_q.push_back({1'b1, 16'h0020, 8'h44});
    beat_q.push_back({1'b1, 16'h0021, 8'h33});
    ref_mem[16'h0020] = 8'h44;
    ref_mem[16'h0021] = 8'h33;
    @(posedge clk); #1;                 // T+1
    bus.p0_req = 1'b0;
    @(posedge clk); #1;                 // T+2
    rst_n = 1'b0;
    @(posedge clk);                     // reset sampled here
    @(negedge clk);
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    check_zero("rst_mid");
    chk("rst_mid_beats_left", 64'(beat_q.size()), 64'h0);
    beat_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);          // no late done may appear
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_ord [4];
    logic [31:0] a;
    exp_ord = '{1, 0, 1, 0};
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = 8'($urandom);
      sram[i]    = ref_mem[i];
    end
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    set_port(0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tie from reset: port 1 first, then strict alternation.
    run_held(1, 1, 2, 2, 1);
    chk("arb_count", 64'(gord.size()), 64'h4);
    for (int i = 0; i < 4 && i < gord.size(); i++)
      chk("arb_order", 64'(gord[i]), 64'(exp_ord[i]));

    issue(1, 1'b1, 32'h10, 32'hA1B2C3D4);
    issue(0, 1'b0, 32'h10, 32'h0);
    chk("plan_read_word", {32'h0, bus.p0_rdata}, 64'hA1B2C3D4);

    issue(0, 1'b0, 32'h0FFD, 32'h0);
    issue(0, 1'b0, 32'h0FFE, 32'h0);
    issue(1, 1'b0, 32'hFFFFFFFE, 32'h0);
    issue(1, 1'b1, 32'h0FFE, 32'hDEADBEEF);

    run_held(1, 0, 2, 0, 0);
    if (gcy.size() == 2) chk("b2b_spacing", 64'(gcy[1] - gcy[0]), 64'h7);
    else chk("b2b_count", 64'(gcy.size()), 64'h2);

    reset_mid_write();
    issue(1, 1'b0, 32'h20, 32'h0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h0FFE + 32'($urandom_range(0, 4096));
      else a = 32'($urandom_range(0, 32'h0FFD));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    run_held(1, 1, 4, 4, 1);

    repeat (4) @(negedge clk);
    chk("end_exp_q", 64'(exp_q.size()), 64'h0);
    chk("end_beat_q", 64'(beat_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter in front of the byte-wide data memory. It shares one 8-bit synchronous SRAM port between two 32-bit requesters: port 0 is instruction fetch and port 1 is load/store. Each granted word access becomes four little-endian byte beats, with byte k at address addr+k in lane [8k+7:8k]. Responses go back to the granted port with a done pulse.

## Interface
- `MEM_TOP`, default 16'h1000: highest valid byte address.
- `AW`, default 16: memory address width.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `p0_req`, `p1_req` in 1: request level.
- `p0_rw`, `p1_rw` in 1: 0 = read, 1 = write.
- `p0_addr`, `p1_addr` in 32: byte address; need not be aligned.
- `p0_wdata`, `p1_wdata` in 32: write word.
- `p0_gnt`, `p1_gnt` out 1: one-cycle accept pulse; `addr`, `rw` and `wdata` are sampled in this cycle.
- `p0_done`, `p1_done` out 1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` out 32: read word. Updated only on that port's read done, held otherwise.
- `p0_err`, `p1_err` out 1: valid with done; high for an out-of-range access.
- `mem_en` out 1: memory beat strobe.
- `mem_we` out 1: write enable, qualified by `mem_en`.
- `mem_addr` out AW: byte address.
- `mem_wdata` out 8: write byte.
- `mem_rdata` in 8: read byte, valid the cycle after the `mem_en` read beat (1-cycle latency).

## Operation
- **States:** IDLE, ISSUE, DRAIN, RESP. A 2-bit beat counter `bc` and a 1-bit round-robin pointer `last` are kept.
- **Arbitration in IDLE:**
  - Only one port requesting: that port is granted.
  - Both requesting: the port other than `last` is granted.
  - `last` is set to the granted port.
- **Grant capture:** on grant, latch port id, rw, addr and wdata. Range check uses full 32 bits: addr + 3 > MEM_TOP (or addr + 3 overflowing 32 bits) is an error.
  - Error: go to RESP with err = 1. No memory beats are issued.
  - Otherwise: go to ISSUE with `bc` = 0.
- **ISSUE:**
  - Drive `mem_en` = 1, `mem_addr` = addr[AW-1:0] + bc, `mem_we` = rw, `mem_wdata` = wdata[8*bc +: 8].
  - At `bc` = 3: a read goes to DRAIN, a write goes to RESP.
  - Otherwise `bc` increments.
- **Read capture:** in the cycle after each read beat, `mem_rdata` is captured into lane bc_prev of a staging word. DRAIN captures lane 3 with `mem_en` = 0.
- **RESP:**
  - Pulse done for the latched port and drive err.
  - On a good read, load that port's rdata from the staging word.
  - Next state is IDLE.
- **Grant timing:** grant is only possible in IDLE. A req still high in the IDLE after done is treated as a new request.
- **Write:** bytes are written in ascending address order.
- **Reset:**
  - All outputs go to 0: gnt, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata.
  - State returns to IDLE, `bc` = 0, `last` = 0, so port 1 wins the first tie.
  - Reset mid-access aborts the access with no done. Bytes already written stay written.
- **Outside ISSUE:** `mem_en` and `mem_we` are 0. `mem_addr` and `mem_wdata` hold their last value.

## Timing
Grant in cycle T for every case below.
- **Read:**
  - Beats in T+1..T+4.
  - Bytes land T+2..T+5 (DRAIN at T+5).
  - done and rdata in T+6.
  - Next grant T+7 at the earliest.
- **Write:**
  - Beats in T+1..T+4.
  - done in T+5.
  - Next grant T+6 at the earliest.
- **Error:**
  - done and err in T+1.
  - Next grant T+2 at the earliest.
- **Other rules:**
  - Done is never asserted on both ports in the same cycle.
  - gnt never coincides with ISSUE, DRAIN or RESP.
  - Requests are ignored while busy. The requester holds req until gnt; `addr` and `wdata` may change after gnt.

## Test plan
- **Port 1 write:** addr 0x10, wdata 0xA1B2C3D4 -> beats at 0x10..0x13 carry D4, C3, B2, A1 with `mem_we` = 1; p1_done at T+5 with err = 0.
- **Port 0 read of the same word:** -> `mem_en` at T+1..T+4; p0_done at T+6 with p0_rdata = 0xA1B2C3D4; p1_rdata unchanged.
- **Simultaneous requests from reset, both held high:**
  - Grants alternate p1, p0, p1.
  - No overlapping memory beats.
  - Each port gets exactly one done per grant.
- **Boundary reads:**
  - Unaligned read at 0x0FFD (addr + 3 = 0x1000): succeeds.
  - Read at 0x0FFE: err at T+1, no `mem_en`, rdata held.
  - Read at 0xFFFFFFFE: err.
- **Reset mid-write:** `rst_n` low at T+3 of a write to 0x20 (wdata 0x11223344) -> beats for 0x20 and 0x21 only; every output 0 the next cycle; no done; re-request after reset is granted normally.
- **Back-to-back reads on port 0:** req held high -> second gnt exactly at T+7; throughput one word per 7 cycles.
